// File: rtl/bcd_score_counter_if.sv
// rtl/bcd_score_counter_if.sv - control and status bundle for the BCD score counter
//
// Purpose: groups the counter's request inputs and value/status outputs.
// Signals:
//   en      count enable
//   clr     synchronous clear to INIT
//   inc     increment request (level or strobe)
//   dec     decrement request (level or strobe)
//   count   BCD value, one nibble per digit, ones in [3:0]
//   is_zero count == 0000
//   is_max  count == 9999
//   changed one-cycle pulse when count took a new value
// Modports: master drives requests and observes status; slave is the counter.
interface bcd_score_counter_if;
  logic        en;
  logic        clr;
  logic        inc;
  logic        dec;
  logic [15:0] count;
  logic        is_zero;
  logic        is_max;
  logic        changed;

  modport master (
    output en, clr, inc, dec,
    input  count, is_zero, is_max, changed
  );

  modport slave (
    input  en, clr, inc, dec,
    output count, is_zero, is_max, changed
  );
endinterface

// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - four-digit saturating BCD up/down counter
//
// Purpose: holds the score/energy value as four BCD digits feeding the
// seven-segment digit muxes, with zero/max flags and a change pulse.
// Parameters:
//   EDGE_DET  1: inc/dec count on their rising edge; 0: count every high cycle
//   INIT      BCD value loaded on reset and on clr (each nibble 0-9)
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   sb   slave side of bcd_score_counter_if (en/clr/inc/dec in,
//        count/is_zero/is_max/changed out)
module bcd_score_counter #(
  parameter bit          EDGE_DET = 1'b1,
  parameter logic [15:0] INIT     = 16'h0000
) (
  input logic                 clk,
  input logic                 rst,
  bcd_score_counter_if.slave  sb
);

  logic [15:0] count_q, count_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        changed_q, changed_d;
  logic        inc_ev, dec_ev;
  logic        at_max, at_zero;

  // Add one with the carry rippling through all four digits in one cycle.
  function automatic logic [15:0] bcd_plus_one(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Subtract one with the borrow rippling through all four digits.
  function automatic logic [15:0] bcd_minus_one(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign at_max  = (count_q == 16'h9999);
  assign at_zero = (count_q == 16'h0000);

  always_comb begin
    inc_ev    = EDGE_DET ? (sb.inc & ~inc_q) : sb.inc;
    dec_ev    = EDGE_DET ? (sb.dec & ~dec_q) : sb.dec;
    // Edge history tracks the inputs every cycle, even while en is low, so
    // raising en under an already-high request does not count.
    inc_d     = sb.inc;
    dec_d     = sb.dec;
    count_d   = count_q;

    if (sb.clr) begin
      count_d = INIT;
    end else if (sb.en) begin
      if (inc_ev && !dec_ev && !at_max) begin
        count_d = bcd_plus_one(count_q);
      end else if (dec_ev && !inc_ev && !at_zero) begin
        count_d = bcd_minus_one(count_q);
      end
    end

    // Saturated or cancelled requests leave count_d equal to count_q, so
    // they never pulse; a repeated clr pulses only on its first cycle.
    changed_d = (count_d != count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= INIT;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      changed_q <= changed_d;
    end
  end

  assign sb.count   = count_q;
  assign sb.is_zero = at_zero;
  assign sb.is_max  = at_max;
  assign sb.changed = changed_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// tb/tb_bcd_score_counter.sv - self-checking bench for bcd_score_counter
module tb_bcd_score_counter;

  logic clk;
  logic rst;
  logic en_r, clr_r, inc_r, dec_r;

  int total = 0;
  int bad   = 0;

  // u0: edge-detect, INIT 0000; u1: edge-detect, INIT 0100; u2: strobe, INIT 0000
  bcd_score_counter_if if0 ();
  bcd_score_counter_if if1 ();
  bcd_score_counter_if if2 ();

  assign if0.en = en_r;  assign if0.clr = clr_r;  assign if0.inc = inc_r;  assign if0.dec = dec_r;
  assign if1.en = en_r;  assign if1.clr = clr_r;  assign if1.inc = inc_r;  assign if1.dec = dec_r;
  assign if2.en = en_r;  assign if2.clr = clr_r;  assign if2.inc = inc_r;  assign if2.dec = dec_r;

  bcd_score_counter #(.EDGE_DET(1'b1), .INIT(16'h0000)) u0 (.clk(clk), .rst(rst), .sb(if0));
  bcd_score_counter #(.EDGE_DET(1'b1), .INIT(16'h0100)) u1 (.clk(clk), .rst(rst), .sb(if1));
  bcd_score_counter #(.EDGE_DET(1'b0), .INIT(16'h0000)) u2 (.clk(clk), .rst(rst), .sb(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal value as a plain integer, previous input levels.
  int mval [3];
  bit mpi  [3];
  bit mpd  [3];
  bit mchg [3];
  int minit [3] = '{0, 100, 0};
  bit medge [3] = '{1'b1, 1'b1, 1'b0};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mval[k] = minit[k];
      mpi[k]  = 1'b0;
      mpd[k]  = 1'b0;
      mchg[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit ie, de;
        int nv;
        ie = medge[k] ? (inc_r && !mpi[k]) : inc_r;
        de = medge[k] ? (dec_r && !mpd[k]) : dec_r;
        nv = mval[k];
        if (clr_r)                nv = minit[k];
        else if (!en_r)           nv = mval[k];
        else if (ie && de)        nv = mval[k];
        else if (ie && nv < 9999) nv = nv + 1;
        else if (de && nv > 0)    nv = nv - 1;
        mchg[k] = (nv != mval[k]);
        mval[k] = nv;
        mpi[k]  = inc_r;
        mpd[k]  = dec_r;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input int k, input logic [15:0] cnt,
                          input logic z, input logic m, input logic ch);
    chk({tag, ".count"},   cnt,        to_bcd(mval[k]));
    chk({tag, ".is_zero"}, 16'(z),     16'(mval[k] == 0));
    chk({tag, ".is_max"},  16'(m),     16'(mval[k] == 9999));
    chk({tag, ".changed"}, 16'(ch),    16'(mchg[k]));
  endtask

  task automatic check_all();
    chk_inst("u0", 0, if0.count, if0.is_zero, if0.is_max, if0.changed);
    chk_inst("u1", 1, if1.count, if1.is_zero, if1.is_max, if1.changed);
    chk_inst("u2", 2, if2.count, if2.is_zero, if2.is_max, if2.changed);
  endtask

  // One clock: drive at the falling edge, update model at the rising edge,
  // compare shortly after it.
  task automatic cyc(input logic e, input logic c, input logic i, input logic d);
    @(negedge clk);
    en_r = e; clr_r = c; inc_r = i; dec_r = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    en_r = 1'b0; clr_r = 1'b0; inc_r = 1'b0; dec_r = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_u0_count", if0.count, 16'h0000);
    chk("reset_u0_zero", 16'(if0.is_zero), 16'd1);
    chk("reset_u1_count", if1.count, 16'h0100);
    chk("reset_u1_changed", 16'(if1.changed), 16'd0);
    rst = 1'b0;

    // Level inc held for five cycles counts once on the edge-detect counter.
    cyc(1, 0, 1, 0);
    chk("level_first_count", if0.count, 16'h0001);
    chk("level_first_changed", 16'(if0.changed), 16'd1);
    chk("level_first_zero", 16'(if0.is_zero), 16'd0);
    for (int n = 0; n < 4; n++) cyc(1, 0, 1, 0);
    chk("level_held_count", if0.count, 16'h0001);
    chk("level_held_changed", 16'(if0.changed), 16'd0);
    cyc(1, 0, 0, 0);

    // Walk u0 up to 0999, then exercise full carry and borrow ripple.
    for (int n = 0; n < 998; n++) begin
      cyc(1, 0, 1, 0);
      cyc(1, 0, 0, 0);
    end
    chk("ripple_start", if0.count, 16'h0999);
    cyc(1, 0, 1, 0);
    chk("ripple_carry", if0.count, 16'h1000);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("ripple_borrow", if0.count, 16'h0999);
    cyc(1, 0, 0, 0);

    // Saturation at the top on the strobe counter.
    for (int n = 0; n < 9999; n++) cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk("sat_max_count", if2.count, 16'h9999);
    chk("sat_max_flag", 16'(if2.is_max), 16'd1);
    chk("sat_max_changed", 16'(if2.changed), 16'd0);

    // Saturation at the bottom on the strobe counter.
    for (int n = 0; n < 10000; n++) cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("sat_zero_count", if2.count, 16'h0000);
    chk("sat_zero_flag", 16'(if2.is_zero), 16'd1);
    chk("sat_zero_changed", 16'(if2.changed), 16'd0);
    cyc(1, 0, 0, 0);

    // Decrement at zero on the edge-detect counter.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    chk("u0_dec_at_zero", if0.count, 16'h0000);
    chk("u0_dec_at_zero_changed", 16'(if0.changed), 16'd0);
    cyc(1, 0, 0, 0);

    // Simultaneous inc/dec edges at 0042 cancel.
    for (int n = 0; n < 42; n++) begin
      cyc(1, 0, 1, 0);
      cyc(1, 0, 0, 0);
    end
    chk("u0_at_42", if0.count, 16'h0042);
    cyc(1, 0, 1, 1);
    chk("both_count", if0.count, 16'h0042);
    chk("both_changed", 16'(if0.changed), 16'd0);
    cyc(1, 0, 0, 0);

    // Disabled edge is consumed; raising en under a held inc does not count.
    cyc(0, 0, 1, 0);
    chk("en_low_count", if0.count, 16'h0042);
    cyc(1, 0, 1, 0);
    chk("en_raise_count", if0.count, 16'h0042);
    cyc(1, 0, 0, 0);

    // Priority: clr beats inc on u1 (INIT 0100) sitting at 0357.
    cyc(1, 1, 0, 0);
    for (int n = 0; n < 257; n++) begin
      cyc(1, 0, 1, 0);
      cyc(1, 0, 0, 0);
    end
    chk("u1_at_357", if1.count, 16'h0357);
    cyc(1, 1, 1, 0);
    chk("clr_inc_count", if1.count, 16'h0100);
    chk("clr_inc_changed", 16'(if1.changed), 16'd1);
    cyc(1, 1, 1, 0);
    chk("clr_held_changed", 16'(if1.changed), 16'd0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    chk("pre_rst_changed", 16'(if1.changed), 16'd1);

    // Reset between edges takes effect without a clock.
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("async_rst_count", if1.count, 16'h0100);
    chk("async_rst_changed", 16'(if1.changed), 16'd0);
    cyc(1, 0, 1, 0);
    rst = 1'b0;
    // inc already high across reset release counts exactly once.
    cyc(1, 0, 1, 0);
    chk("post_rst_edge", if1.count, 16'h0101);
    cyc(1, 0, 1, 0);
    chk("post_rst_held", if1.count, 16'h0101);
    cyc(1, 0, 0, 0);

    // Strobe mode: inc high for consecutive cycles counts every cycle.
    cyc(1, 1, 0, 0);
    for (int n = 0; n < 8; n++) cyc(1, 0, 1, 0);
    chk("strobe_at_8", if2.count, 16'h0008);
    cyc(1, 0, 1, 0);
    chk("strobe_9", if2.count, 16'h0009);
    cyc(1, 0, 1, 0);
    chk("strobe_10", if2.count, 16'h0010);
    cyc(1, 0, 1, 0);
    chk("strobe_11", if2.count, 16'h0011);
    cyc(1, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
          1'($urandom), 1'($urandom));
    end
    rst = 1'b0;
    cyc(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
